// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory bus arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_ACC
   } owner_t;

   localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
   localparam logic [31:0] DEF_ERR_RDATA      = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_watchdog.sv
// rtl/mem_bus_watchdog.sv - counts BUSY cycles and flags a hung transaction
module mem_bus_watchdog
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic busy,
   output logic expire
);

   if (TIMEOUT_CYCLES == 0) begin : g_off
      // Watchdog disabled: never expires, inputs intentionally ignored.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset, start, busy};
      assign expire        = 1'b0;
   end else begin : g_on
      localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;

      // Cleared on every grant, counts BUSY cycles and parks at the last value.
      always_ff @(posedge clk) begin
         if (reset || start) begin
            count_q <= '0;
         end else if (busy && (count_q != LAST)) begin
            count_q <= count_q + CW'(1);
         end
      end

      assign expire = busy && (count_q == LAST);
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-way round-robin arbiter for the native memory port
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_valid,
   input  logic        cpu_instr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_wstrb,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   input  logic        acc_valid,
   input  logic [31:0] acc_addr,
   input  logic [31:0] acc_wdata,
   input  logic [3:0]  acc_wstrb,
   output logic        acc_ready,
   output logic [31:0] acc_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        grant_acc,
   output logic        timeout_err,
   input  logic        err_clear
);

   state_t      state_q, state_d;
   owner_t      owner_q, last_owner_q, grant_owner;
   logic        grant, complete, expire, busy;
   logic [31:0] rsp_data;

   assign busy     = (state_q == BUSY);
   // A real response always beats a coincident watchdog expiry.
   assign rsp_data = mem_ready ? mem_rdata : ERR_RDATA;

   mem_bus_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk   (clk),
      .reset (reset),
      .start (grant),
      .busy  (busy),
      .expire(expire)
   );

   // Next state, round-robin pick in IDLE and completion detect in BUSY.
   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      grant_owner = owner_q;
      complete    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_valid && acc_valid) begin
               grant       = 1'b1;
               grant_owner = (last_owner_q == OWN_ACC) ? OWN_CPU : OWN_ACC;
            end else if (cpu_valid) begin
               grant       = 1'b1;
               grant_owner = OWN_CPU;
            end else if (acc_valid) begin
               grant       = 1'b1;
               grant_owner = OWN_ACC;
            end
            if (grant) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready || expire) begin
               complete = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register plus ownership history used for fairness.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_ACC;
         grant_acc    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            owner_q      <= grant_owner;
            last_owner_q <= grant_owner;
            grant_acc    <= (grant_owner == OWN_ACC);
         end else if (state_q == DONE) begin
            grant_acc <= 1'b0;
         end
      end
   end

   // Downstream request registers: loaded on grant, held through BUSY.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid <= 1'b0;
         mem_instr <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else if (grant) begin
         mem_valid <= 1'b1;
         if (grant_owner == OWN_ACC) begin
            mem_instr <= 1'b0;
            mem_addr  <= acc_addr;
            mem_wdata <= acc_wdata;
            mem_wstrb <= acc_wstrb;
         end else begin
            mem_instr <= cpu_instr;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_wstrb <= cpu_wstrb;
         end
      end else if (complete) begin
         mem_valid <= 1'b0;
      end
   end

   // Upstream responses: one-cycle ready pulse, rdata held afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_ready <= 1'b0;
         cpu_rdata <= '0;
         acc_ready <= 1'b0;
         acc_rdata <= '0;
      end else begin
         cpu_ready <= complete && (owner_q == OWN_CPU);
         acc_ready <= complete && (owner_q == OWN_ACC);
         if (complete && (owner_q == OWN_CPU)) begin
            cpu_rdata <= rsp_data;
         end
         if (complete && (owner_q == OWN_ACC)) begin
            acc_rdata <= rsp_data;
         end
      end
   end

   // Sticky watchdog flag; a new expiry wins over a same-edge clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else if (complete && !mem_ready) begin
         timeout_err <= 1'b1;
      end else if (err_clear) begin
         timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - transaction-model bench for mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam int          TO       = 16;
   localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset, err_clear;
   logic        cpu_valid, cpu_instr, acc_valid, mem_ready;
   logic [31:0] cpu_addr, cpu_wdata, acc_addr, acc_wdata, mem_rdata;
   logic [3:0]  cpu_wstrb, acc_wstrb;
   logic        cpu_ready, acc_ready, mem_valid, mem_instr, grant_acc, timeout_err;
   logic [31:0] cpu_rdata, acc_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;

   mem_bus_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .ERR_RDATA     (ERR_WORD)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .acc_valid(acc_valid), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
      .acc_wstrb(acc_wstrb), .acc_ready(acc_ready), .acc_rdata(acc_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .grant_acc(grant_acc), .timeout_err(timeout_err), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Transaction model: who holds the bus, how long it has waited, whether it has answered.
   int          m_owner;      // -1 none, 0 cpu, 1 acc
   int          m_age;
   int          m_last;
   bit          m_done, m_err, m_instr;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [31:0] m_rd [2];

   // Stimulus control.
   int          cpu_left, acc_left, wait_cfg, wait_left;
   bit          rand_mode, prev_mv, use_fix;
   logic [31:0] rdata_fix;

   // Observations from the last run_txn.
   int          cpu_pulses, acc_pulses, busy_cycles, first_mv_step, cpu_ready_step;
   logic [31:0] seen_cpu_rd, g_addr, g_wdata;
   logic [3:0]  g_wstrb;
   logic        seen_err;
   bit          g_acc[$];
   bit          g_instr[$];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_advance();
      bit set_err;
      int who;
      set_err = 1'b0;
      if (reset) begin
         m_owner = -1; m_done = 0; m_age = 0; m_last = 1; m_err = 0;
         m_instr = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
         m_rd[0] = '0; m_rd[1] = '0;
      end else begin
         if (m_owner < 0) begin
            who = -1;
            if (cpu_valid && acc_valid) who = 1 - m_last;
            else if (cpu_valid)         who = 0;
            else if (acc_valid)         who = 1;
            if (who == 0) begin
               m_addr = cpu_addr; m_wdata = cpu_wdata; m_wstrb = cpu_wstrb; m_instr = cpu_instr;
            end else if (who == 1) begin
               m_addr = acc_addr; m_wdata = acc_wdata; m_wstrb = acc_wstrb; m_instr = 0;
            end
            if (who >= 0) begin
               m_owner = who; m_last = who; m_age = 0; m_done = 0;
            end
         end else if (!m_done) begin
            if (mem_ready) begin
               m_rd[m_owner] = mem_rdata; m_done = 1;
            end else if (TO > 0 && m_age == TO - 1) begin
               m_rd[m_owner] = ERR_WORD; m_done = 1; set_err = 1;
            end else begin
               m_age++;
            end
         end else begin
            m_owner = -1; m_done = 0;
         end
         if (set_err)        m_err = 1;
         else if (err_clear) m_err = 0;
      end
   endtask

   task automatic compare_all();
      chk("mem_valid",   mem_valid,   (m_owner >= 0) && !m_done);
      chk("mem_instr",   mem_instr,   m_instr);
      chk("mem_addr",    mem_addr,    m_addr);
      chk("mem_wdata",   mem_wdata,   m_wdata);
      chk("mem_wstrb",   mem_wstrb,   m_wstrb);
      chk("cpu_ready",   cpu_ready,   m_done && (m_owner == 0));
      chk("acc_ready",   acc_ready,   m_done && (m_owner == 1));
      chk("cpu_rdata",   cpu_rdata,   m_rd[0]);
      chk("acc_rdata",   acc_rdata,   m_rd[1]);
      chk("grant_acc",   grant_acc,   m_owner == 1);
      chk("timeout_err", timeout_err, m_err);
   endtask

   task automatic raise_cpu();
      cpu_valid = 1'b1;
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      cpu_instr = 1'($urandom);
   endtask

   task automatic raise_acc();
      acc_valid = 1'b1;
      acc_addr  = $urandom;
      acc_wdata = $urandom;
      acc_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
   endtask

   // Requesters drop or renew valid on the edge after their ready pulse; memory adds wait states.
   task automatic drive();
      if (rand_mode) begin
         reset     = ($urandom_range(0, 199) == 0);
         err_clear = ($urandom_range(0, 7) == 0);
      end
      if (reset) begin
         cpu_valid = 1'b0;
         acc_valid = 1'b0;
      end else begin
         if (cpu_valid && m_done && m_owner == 0) begin
            cpu_valid = 1'b0; cpu_left--;
            if (cpu_left > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) raise_cpu();
         end else if (!cpu_valid && cpu_left > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
            raise_cpu();
         end
         if (acc_valid && m_done && m_owner == 1) begin
            acc_valid = 1'b0; acc_left--;
            if (acc_left > 0 && (!rand_mode || $urandom_range(0, 1) == 1)) raise_acc();
         end else if (!acc_valid && acc_left > 0 && (!rand_mode || $urandom_range(0, 2) == 0)) begin
            raise_acc();
         end
      end
      mem_rdata = use_fix ? rdata_fix : $urandom;
      if (m_owner >= 0 && !m_done) begin
         if (!prev_mv)
            wait_left = (wait_cfg >= 0) ? wait_cfg
                      : (($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4)));
         mem_ready = (wait_left == 0);
         if (wait_left > 0) wait_left--;
         prev_mv = 1'b1;
      end else begin
         mem_ready = 1'b0;
         prev_mv   = 1'b0;
      end
   endtask

   task automatic step();
      model_advance();
      @(posedge clk);
      #1;
      compare_all();
      drive();
   endtask

   task automatic run_txn(input int max_steps, output int steps);
      bit dut_prev_mv;
      steps = 0; cpu_pulses = 0; acc_pulses = 0; busy_cycles = 0;
      first_mv_step = 0; cpu_ready_step = 0;
      g_acc.delete(); g_instr.delete();
      dut_prev_mv = mem_valid;
      do begin
         step();
         steps++;
         if (cpu_ready) begin
            cpu_pulses++; cpu_ready_step = steps; seen_cpu_rd = cpu_rdata; seen_err = timeout_err;
         end
         if (acc_ready) acc_pulses++;
         if (mem_valid) busy_cycles++;
         if (mem_valid && first_mv_step == 0) first_mv_step = steps;
         if (mem_valid && !dut_prev_mv) begin
            if (g_acc.size() == 0) begin
               g_addr = mem_addr; g_wdata = mem_wdata; g_wstrb = mem_wstrb;
            end
            g_acc.push_back(grant_acc);
            g_instr.push_back(mem_instr);
         end
         dut_prev_mv = mem_valid;
      end while (!(cpu_left == 0 && acc_left == 0 && m_owner < 0 && !cpu_valid && !acc_valid)
                 && steps < max_steps);
      checks++;
      if (steps >= max_steps) begin
         failures++;
         $display("FAIL run_bound: got %0d steps, required fewer than %0d", steps, max_steps);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; cpu_valid = 1'b0; acc_valid = 1'b0; cpu_left = 0; acc_left = 0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      int n, ap;
      reset = 1'b1; err_clear = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      cpu_valid = 0; cpu_instr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
      acc_valid = 0; acc_addr = '0; acc_wdata = '0; acc_wstrb = '0;
      cpu_left = 0; acc_left = 0; wait_cfg = 0; wait_left = 0;
      rand_mode = 0; prev_mv = 0; use_fix = 0; rdata_fix = '0;
      m_owner = -1; m_done = 0; m_age = 0; m_last = 1; m_err = 0;
      do_reset();
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_grant_acc", grant_acc, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_timeout_err", timeout_err, 0);

      // Single CPU read with two wait states.
      use_fix = 1; rdata_fix = 32'h12345678; mem_rdata = rdata_fix; wait_cfg = 2;
      cpu_addr = 32'h00800000; cpu_wdata = '0; cpu_wstrb = 4'h0; cpu_instr = 0;
      cpu_valid = 1; cpu_left = 1;
      run_txn(20, n);
      chk("t1_mem_valid_latency", first_mv_step, 1);
      chk("t1_mem_addr", g_addr, 32'h00800000);
      chk("t1_ready_step", cpu_ready_step, 4);
      chk("t1_cpu_pulses", cpu_pulses, 1);
      chk("t1_cpu_rdata", seen_cpu_rd, 32'h12345678);
      chk("t1_acc_pulses", acc_pulses, 0);
      use_fix = 0;

      // Simultaneous first requests after reset: CPU first.
      do_reset();
      wait_cfg = 0;
      raise_cpu(); cpu_instr = 1; raise_acc(); cpu_left = 1; acc_left = 1;
      run_txn(30, n);
      chk("t2_grants", g_acc.size(), 2);
      if (g_acc.size() == 2) begin
         chk("t2_first_is_cpu", g_acc[0], 0);
         chk("t2_first_instr", g_instr[0], 1);
         chk("t2_second_is_acc", g_acc[1], 1);
         chk("t2_second_instr", g_instr[1], 0);
      end

      // Sustained contention, zero-wait memory.
      do_reset();
      wait_cfg = 0; cpu_left = 8; acc_left = 8;
      raise_cpu(); raise_acc();
      run_txn(200, n);
      chk("t3_cycles", n, 48);
      chk("t3_grants", g_acc.size(), 16);
      for (int i = 0; i < g_acc.size(); i++) chk($sformatf("t3_order_%0d", i), g_acc[i], i % 2);
      chk("t3_cpu_pulses", cpu_pulses, 8);
      chk("t3_acc_pulses", acc_pulses, 8);

      // Accelerator write.
      cpu_instr = 1; wait_cfg = 1;
      acc_addr = 32'h00010040; acc_wdata = 32'hCAFEF00D; acc_wstrb = 4'b1111;
      acc_valid = 1; acc_left = 1;
      run_txn(20, n);
      chk("t4_addr", g_addr, 32'h00010040);
      chk("t4_wdata", g_wdata, 32'hCAFEF00D);
      chk("t4_wstrb", g_wstrb, 4'b1111);
      chk("t4_instr", g_instr.size() > 0 ? g_instr[0] : 1'b1, 0);
      chk("t4_acc_pulses", acc_pulses, 1);
      chk("t4_cpu_pulses", cpu_pulses, 0);

      // Watchdog expiry, sticky flag, clear, then ready on the last allowed cycle.
      raise_cpu(); cpu_wstrb = 4'h0; cpu_left = 1; wait_cfg = 1000;
      run_txn(40, n);
      chk("t5_busy_cycles", busy_cycles, 16);
      chk("t5_err_rdata", seen_cpu_rd, ERR_WORD);
      chk("t5_err_at_ready", seen_err, 1);
      step(); step(); step();
      chk("t5_err_sticky", timeout_err, 1);
      err_clear = 1;
      step();
      err_clear = 0;
      chk("t5_err_cleared", timeout_err, 0);
      use_fix = 1; rdata_fix = 32'h600DDA7A; wait_cfg = 15;
      raise_cpu(); cpu_wstrb = 4'h0; cpu_left = 1;
      run_txn(40, n);
      chk("t5b_busy_cycles", busy_cycles, 16);
      chk("t5b_rdata", seen_cpu_rd, 32'h600DDA7A);
      chk("t5b_no_err", timeout_err, 0);
      use_fix = 0;

      // Reset during an outstanding accelerator read.
      raise_acc(); acc_wstrb = 4'h0; acc_left = 1; wait_cfg = 1000;
      step(); step(); step();
      chk("t6_busy_before", mem_valid, 1);
      reset = 1; acc_valid = 0; acc_left = 0;
      step();
      reset = 0;
      chk("t6_mem_valid", mem_valid, 0);
      chk("t6_grant_acc", grant_acc, 0);
      chk("t6_mem_addr", mem_addr, 0);
      ap = acc_ready ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (acc_ready) ap++;
      end
      chk("t6_no_acc_ready", ap, 0);
      wait_cfg = 0; raise_cpu(); raise_acc(); cpu_left = 1; acc_left = 1;
      run_txn(30, n);
      chk("t6_cpu_first", g_acc.size() > 0 ? g_acc[0] : 1'b1, 0);

      // Randomized traffic with random waits, timeouts, clears and resets.
      rand_mode = 1; wait_cfg = -1; cpu_left = 80; acc_left = 80;
      run_txn(20000, n);
      rand_mode = 0; reset = 0; err_clear = 0;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
